// File: rtl/gate_vector_sequencer.sv
// Sweeps a two-input gate through {a,b} = 0..3, waits a settle interval per vector,
// then samples and holds-checks the gate output against a truth table.
module gate_vector_sequencer #(
  parameter int         SETTLE_CYCLES = 5,
  parameter int         HOLD_CYCLES   = 3,
  parameter logic [3:0] TRUTH         = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Terminal counter values; HOLD_CYCLES=0 skips HOLD entirely so its value is unused then.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST   = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;
  localparam bit         HAS_HOLD    = (HOLD_CYCLES > 0);

  logic [2:0] state;
  logic [1:0] vec;
  logic [7:0] cnt;

  logic       check_en;
  logic       mismatch;
  logic       first_fail;
  logic       vector_end;
  logic [3:0] next_mask;
  logic [2:0] next_err;

  // A vector is counted only on its first failing observation.
  always_comb begin
    check_en   = (state == S_SAMPLE) || (state == S_HOLD);
    mismatch   = (dut_out != TRUTH[vec]);
    first_fail = check_en && mismatch && !fail_mask[vec];
    next_mask  = fail_mask;
    if (first_fail)
      next_mask = fail_mask | (4'b0001 << vec);
    next_err   = err_count + {2'b00, first_fail};
    vector_end = ((state == S_HOLD) && (cnt == HOLD_LAST)) ||
                 ((state == S_SAMPLE) && !HAS_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vec       <= 2'd0;
      cnt       <= 8'd0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_SETTLE;
            vec       <= 2'd0;
            cnt       <= 8'd0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= S_SAMPLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_SAMPLE, S_HOLD: begin
          err_count <= next_err;
          fail_mask <= next_mask;
          if (vector_end) begin
            cnt <= 8'd0;
            if (vec == 2'd3) begin
              // Pass must reflect a failure first seen on this very edge.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (next_err == 3'd0);
              dut_a <= 1'b0;
              dut_b <= 1'b0;
            end else begin
              state          <= S_SETTLE;
              vec            <= vec + 2'd1;
              {dut_a, dut_b} <= vec + 2'd1;
            end
          end else if (state == S_SAMPLE) begin
            state <= S_HOLD;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: default timing, failure accounting,
// a short HOLD_CYCLES=0 instance, and start/reset protocol.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic start  = 1'b0;
  logic glitch = 1'b0;
  int   mode   = 0;

  logic       dut_out, dut_a, dut_b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  logic       out2, a2, b2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [3:0] mask2;

  logic [6:0] dly = 7'd0;
  logic       reg2 = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [1:0]  ab_log    [0:47];
  logic        done_log  [0:47];
  logic        busy_log  [0:47];
  logic [10:0] all_log   [0:47];
  logic [1:0]  ab2_log   [0:47];
  logic        done2_log [0:47];

  gate_vector_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_mask(fail_mask)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(1), .HOLD_CYCLES(0), .TRUTH(4'b1000)) dut2 (
    .clk(clk), .rst(rst), .start(start), .dut_out(out2),
    .dut_a(a2), .dut_b(b2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_mask(mask2)
  );

  // Gate models: dly[0] is a registered AND, dly[6] the same delayed seven cycles.
  always @(posedge clk) begin
    dly  <= {dly[5:0], dut_a & dut_b};
    reg2 <= a2 & b2;
  end

  always_comb begin
    case (mode)
      1:       dut_out = glitch;
      2:       dut_out = glitch | dly[6];
      default: dut_out = glitch | dly[0];
    endcase
    out2 = reg2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start (sampled at edge t0), then logs outputs for cycles t0+1..t0+ncyc.
  task automatic applyStimulus(input int m, input int glitch_cyc, input int extra_start,
                               input int rst_cyc, input int ncyc);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      ab_log[n]    = {dut_a, dut_b};
      done_log[n]  = done;
      busy_log[n]  = busy;
      all_log[n]   = {dut_a, dut_b, busy, done, pass, err_count, fail_mask};
      ab2_log[n]   = {a2, b2};
      done2_log[n] = done2;
      start  = (n == extra_start);
      rst    = (n == rst_cyc);
      glitch = (n == glitch_cyc);
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    rst    = 1'b0;
    glitch = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen_done;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_dut", {dut_a, dut_b, busy, done, pass, err_count, fail_mask}, 32'h0);
    checkOutput("reset_dut2", {a2, b2, busy2, done2, pass2, err2, mask2}, 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Default sweep with a well-behaved gate.
    applyStimulus(0, -1, -1, -1, 40);
    checkOutput("vec0_t1",   ab_log[1],  2'd0);
    checkOutput("vec0_t9",   ab_log[9],  2'd0);
    checkOutput("vec1_t10",  ab_log[10], 2'd1);
    checkOutput("vec2_t19",  ab_log[19], 2'd2);
    checkOutput("vec3_t28",  ab_log[28], 2'd3);
    checkOutput("vec3_t36",  ab_log[36], 2'd3);
    checkOutput("ab_clr_t37", ab_log[37], 2'd0);
    checkOutput("done_t36",  done_log[36], 1'b0);
    checkOutput("done_t37",  done_log[37], 1'b1);
    checkOutput("done_t38",  done_log[38], 1'b0);
    checkOutput("busy_t1",   busy_log[1],  1'b1);
    checkOutput("busy_t36",  busy_log[36], 1'b1);
    checkOutput("busy_t37",  busy_log[37], 1'b0);
    checkOutput("result_ok", {pass, err_count, fail_mask}, 8'h80);
    checkOutput("d2_vec0_t1", ab2_log[1], 2'd0);
    checkOutput("d2_vec1_t3", ab2_log[3], 2'd1);
    checkOutput("d2_vec2_t5", ab2_log[5], 2'd2);
    checkOutput("d2_vec3_t7", ab2_log[7], 2'd3);
    checkOutput("d2_done_t8", done2_log[8], 1'b0);
    checkOutput("d2_done_t9", done2_log[9], 1'b1);
    checkOutput("d2_result",  {pass2, err2, mask2}, 8'h80);

    // Output stuck at 0: only vector 3 fails.
    applyStimulus(1, -1, -1, -1, 40);
    checkOutput("result_stuck0", {pass, err_count, fail_mask}, 8'h18);

    // Output delayed 7 cycles: vector 3 late at SAMPLE, counted once.
    applyStimulus(2, -1, -1, -1, 40);
    checkOutput("result_delay7", {pass, err_count, fail_mask}, 8'h18);

    // One-cycle glitch in the 2nd HOLD cycle of vector 1.
    applyStimulus(0, 17, -1, -1, 40);
    checkOutput("result_glitch", {pass, err_count, fail_mask}, 8'h12);

    // Ignored mid-sweep start, then reset abort.
    applyStimulus(0, -1, 4, 15, 40);
    checkOutput("proto_vec1_t10", ab_log[10], 2'd1);
    checkOutput("proto_vec1_t14", ab_log[14], 2'd1);
    checkOutput("proto_busy_t15", busy_log[15], 1'b1);
    checkOutput("proto_rst_t16", all_log[16], 11'h0);
    seen_done = 1'b0;
    for (int n = 1; n <= 40; n++) seen_done = seen_done | done_log[n];
    checkOutput("proto_no_done", seen_done, 1'b0);

    // A normal sweep afterwards.
    applyStimulus(0, -1, -1, -1, 40);
    checkOutput("rerun_done_t37", done_log[37], 1'b1);
    checkOutput("rerun_result", {pass, err_count, fail_mask}, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
# gate_vector_sequencer

Self-checking stimulus controller for a two-input combinational gate with specified propagation delays. It drives the gate's `a`/`b` inputs through all four input combinations in a fixed order. For each vector it waits a configurable settle interval, samples the gate output, and requires that output to stay stable for a hold interval. Errors are reported per vector and as a pass/fail summary. It sits in the gate-level simulation area beside the device under test (DUT) and sequences that gate's timing characterisation runs.

## Interface
- `SETTLE_CYCLES`, default 5: cycles inputs are held before sampling; legal range 1..255.
- `HOLD_CYCLES`, default 3: cycles after sampling during which the output must stay stable; legal range 0..255.
- `TRUTH`, default 4'b1000: expected output per vector; bit index = {a,b}. The default is AND.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `dut_out`  in  1  gate output under test.
- `dut_a`  out  1  gate input a.
- `dut_b`  out  1  gate input b.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  1 when the last sweep had zero failing vectors; valid from `done`.
- `err_count`  out  3  number of failing vectors in the last sweep (0..4).
- `fail_mask`  out  4  bit k set when vector k failed.

## Operation
- States: IDLE, SETTLE, SAMPLE, HOLD, DONE.
- Vector order is k = 0,1,2,3, with {dut_a,dut_b} = k.
- Reset values:
  - state IDLE.
  - `dut_a`=`dut_b`=0.
  - `busy`=`done`=0.
  - `pass`=0.
  - `err_count`=0, `fail_mask`=0.
- IDLE:
  - `start`=1 moves to SETTLE with vector 0 applied.
  - Clear `err_count`, `fail_mask` and `pass`.
  - Set `busy`.
- SETTLE:
  - Inputs are held.
  - The settle counter counts SETTLE_CYCLES cycles, then moves to SAMPLE.
  - `dut_out` is not checked in this state.
- SAMPLE (1 cycle):
  - Compare `dut_out` with TRUTH[k]; a mismatch marks vector k failed.
  - Go to HOLD if HOLD_CYCLES>0.
  - If HOLD_CYCLES=0, advance as HOLD does on exit.
- HOLD:
  - Lasts HOLD_CYCLES cycles.
  - In each cycle, `dut_out`≠TRUTH[k] marks vector k failed.
  - On exit, if k<3: apply vector k+1 and go to SETTLE. If k=3: go to DONE.
- Failure accounting:
  - Each vector is counted at most once.
  - `err_count` increments only on the first failure mark of vector k.
  - `fail_mask[k]` is set on that same first mark.
- DONE (1 cycle):
  - `done`=1, `busy`=0.
  - `pass`=(`err_count`==0).
  - `dut_a`=`dut_b`=0.
  - Next state is IDLE.
- Results (`pass`, `err_count`, `fail_mask`) hold until the next accepted `start` or `rst`.
- `start` outside IDLE is ignored. This includes `start` during DONE.
- `rst` mid-sweep:
  - Aborts on the next edge; all outputs take reset values.
  - No `done` pulse is produced.

## Timing
- All outputs are registered. `dut_a`/`dut_b` change only on vector transitions and on DONE/reset.
- Let t0 be the edge where `start` is sampled in IDLE.
  - Vector 0 appears after t0, i.e. in cycle t0+1.
  - Per-vector length is P = SETTLE_CYCLES + 1 + HOLD_CYCLES.
  - Vector k occupies cycles t0+1+kP .. t0+(k+1)P.
- The SAMPLE cycle for vector k is t0+1+kP+SETTLE_CYCLES.
- `done` is high in cycle t0+4P+1. `busy` is high in cycles t0+1 .. t0+4P.
- Comparison uses the `dut_out` value present at the rising edge that ends the SAMPLE or HOLD cycle.
- A new `start` is accepted no earlier than cycle t0+4P+2, i.e. IDLE after DONE. Back-to-back sweeps therefore have a one-cycle gap.

## Test plan
- Defaults, with `dut_out` = registered `dut_a`&`dut_b`, `start` at t0:
  - Vectors 00,01,10,11 appear at t0+1, +10, +19, +28.
  - `done` at t0+37.
  - `pass`=1, `err_count`=0, `fail_mask`=0000.
- `dut_out` stuck at 0:
  - Only vector 3 fails.
  - `err_count`=1, `fail_mask`=1000, `pass`=0.
- Delayed-output model:
  - Model `dut_out` as `dut_a`&`dut_b` delayed 7 cycles, with SETTLE_CYCLES=5.
  - Vector 3 fails at SAMPLE and is counted once.
  - `err_count`=1 even though later HOLD cycles also mismatch.
- Glitch in HOLD:
  - Force a one-cycle 1 on `dut_out` in the 2nd HOLD cycle of vector 1.
  - `fail_mask`=0010, `err_count`=1.
- HOLD_CYCLES=0, SETTLE_CYCLES=1:
  - P=2; `done` at t0+9.
  - Vectors at t0+1, +3, +5, +7.
- Protocol:
  - `start` pulsed at t0+4 is ignored.
  - `rst` at t0+15 gives all outputs 0 from t0+16 with no `done`.
  - A subsequent `start` runs a full sweep normally.
